bootrom_word_loader: RTL

- Upstream feeder for the byte/word dual-width boot ROM RAM: takes the 8-bit download byte stream and packs it into little-endian 16-bit words for the RAM's 16-bit write port (address_b/data_b/wren_b).
- Handles out-of-order and partial words by padding, flushes the trailing odd byte at end of download, and reports byte count, checksum, overflow and completion to the simulation harness.

---
 rtl/bootrom_word_loader.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/bootrom_word_loader.sv
// Packs the 8-bit ioctl download stream into little-endian 16-bit words for the
// boot ROM's word write port; pads partial words and reports session statistics.
module bootrom_word_loader #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned BASE     = 0,
  parameter logic [7:0]  INDEX    = 8'h00,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [ADDR_W-2:0] address_b,
  output logic [15:0]       data_b,
  output logic              wren_b,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   byte_count,
  output logic [7:0]        checksum,
  output logic              overflow
);

  localparam int unsigned     WA_W    = ADDR_W - 1;
  localparam logic [24:0]     BASE_L  = 25'(BASE);
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic              sess_d_r;
  logic [WA_W-1:0]   pend_w_r, pend_w_nxt_s;
  logic [7:0]        pend_lo_r, pend_lo_nxt_s;
  logic [7:0]        pend_hi_r, pend_hi_nxt_s;
  logic [1:0]        pend_mask_r, pend_mask_nxt_s;
  logic [ADDR_W:0]   cnt_r, cnt_nxt_s;
  logic [7:0]        sum_r, sum_nxt_s;
  logic              ovf_r, ovf_nxt_s;
  logic              wren_r, wren_nxt_s;
  logic [WA_W-1:0]   addr_r, addr_nxt_s;
  logic [15:0]       data_r, data_nxt_s;
  logic              busy_r, done_r;

  logic              session_s, start_s, fall_s, accept_s, in_range_s, lane_s;
  logic [24:0]       off_s;
  logic [WA_W-1:0]   w_s;
  logic [7:0]        m_lo_s, m_hi_s;
  logic [1:0]        m_mask_s;

  function automatic logic [15:0] pad_word(input logic [7:0] hi, input logic [7:0] lo,
                                           input logic [1:0] mask);
    pad_word = {(mask[1] ? hi : PAD_BYTE), (mask[0] ? lo : PAD_BYTE)};
  endfunction

  assign session_s  = ioctl_download && (ioctl_index == INDEX);
  assign start_s    = session_s && !sess_d_r;
  assign fall_s     = !session_s && sess_d_r;
  assign off_s      = ioctl_addr - BASE_L;
  assign in_range_s = (ioctl_addr >= BASE_L) && ((off_s >> ADDR_W) == 25'd0);
  assign w_s        = off_s[ADDR_W-1:1];
  assign lane_s     = off_s[0];
  assign accept_s   = (state_r == ST_LOAD) && session_s && ioctl_wr;

  // Session FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (start_s) state_nxt_s = ST_LOAD; else state_nxt_s = ST_IDLE;
      ST_LOAD:  if (fall_s) state_nxt_s = ST_FLUSH; else state_nxt_s = ST_LOAD;
      ST_FLUSH: state_nxt_s = ST_DONE;
      ST_DONE:  if (start_s) state_nxt_s = ST_LOAD; else state_nxt_s = ST_DONE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Byte merge, word emission and statistics
  always_comb begin
    pend_w_nxt_s    = pend_w_r;
    pend_lo_nxt_s   = pend_lo_r;
    pend_hi_nxt_s   = pend_hi_r;
    pend_mask_nxt_s = pend_mask_r;
    cnt_nxt_s       = cnt_r;
    sum_nxt_s       = sum_r;
    ovf_nxt_s       = ovf_r;
    wren_nxt_s      = 1'b0;
    addr_nxt_s      = addr_r;
    data_nxt_s      = data_r;
    m_lo_s          = lane_s ? pend_lo_r : ioctl_dout;
    m_hi_s          = lane_s ? ioctl_dout : pend_hi_r;
    m_mask_s        = pend_mask_r | (lane_s ? 2'b10 : 2'b01);

    if (start_s && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
      cnt_nxt_s       = '0;
      sum_nxt_s       = 8'h00;
      ovf_nxt_s       = 1'b0;
      pend_mask_nxt_s = 2'b00;
    end else if ((state_r == ST_LOAD) && fall_s) begin
      // The trailing partial word is written as the FSM enters FLUSH
      if (pend_mask_r != 2'b00) begin
        wren_nxt_s = 1'b1;
        addr_nxt_s = pend_w_r;
        data_nxt_s = pad_word(pend_hi_r, pend_lo_r, pend_mask_r);
      end else begin
        wren_nxt_s = 1'b0;
      end
      pend_mask_nxt_s = 2'b00;
    end else if (accept_s) begin
      if (!in_range_s) begin
        ovf_nxt_s = 1'b1;
      end else begin
        if (cnt_r != CNT_MAX) cnt_nxt_s = cnt_r + CNT_ONE; else cnt_nxt_s = cnt_r;
        sum_nxt_s = sum_r + ioctl_dout;
        if ((pend_mask_r == 2'b00) || (pend_w_r != w_s)) begin
          if (pend_mask_r != 2'b00) begin
            wren_nxt_s = 1'b1;
            addr_nxt_s = pend_w_r;
            data_nxt_s = pad_word(pend_hi_r, pend_lo_r, pend_mask_r);
          end else begin
            wren_nxt_s = 1'b0;
          end
          pend_w_nxt_s    = w_s;
          pend_mask_nxt_s = lane_s ? 2'b10 : 2'b01;
          if (lane_s) pend_hi_nxt_s = ioctl_dout; else pend_lo_nxt_s = ioctl_dout;
        end else if (m_mask_s == 2'b11) begin
          wren_nxt_s      = 1'b1;
          addr_nxt_s      = pend_w_r;
          data_nxt_s      = {m_hi_s, m_lo_s};
          pend_mask_nxt_s = 2'b00;
        end else begin
          pend_lo_nxt_s   = m_lo_s;
          pend_hi_nxt_s   = m_hi_s;
          pend_mask_nxt_s = m_mask_s;
        end
      end
    end else begin
      wren_nxt_s = 1'b0;
    end
  end

  // FSM state and session edge history; history resets high so a download
  // still asserted across reset does not look like a fresh start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      sess_d_r <= 1'b1;
    end else begin
      state_r  <= state_nxt_s;
      sess_d_r <= session_s;
    end
  end

  // Pending word, statistics and registered RAM/status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_w_r    <= '0;
      pend_lo_r   <= 8'h00;
      pend_hi_r   <= 8'h00;
      pend_mask_r <= 2'b00;
      cnt_r       <= '0;
      sum_r       <= 8'h00;
      ovf_r       <= 1'b0;
      wren_r      <= 1'b0;
      addr_r      <= '0;
      data_r      <= 16'h0000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      pend_w_r    <= pend_w_nxt_s;
      pend_lo_r   <= pend_lo_nxt_s;
      pend_hi_r   <= pend_hi_nxt_s;
      pend_mask_r <= pend_mask_nxt_s;
      cnt_r       <= cnt_nxt_s;
      sum_r       <= sum_nxt_s;
      ovf_r       <= ovf_nxt_s;
      wren_r      <= wren_nxt_s;
      addr_r      <= addr_nxt_s;
      data_r      <= data_nxt_s;
      busy_r      <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_FLUSH);
      done_r      <= (state_nxt_s == ST_DONE);
    end
  end

  assign address_b  = addr_r;
  assign data_b     = data_r;
  assign wren_b     = wren_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign byte_count = cnt_r;
  assign checksum   = sum_r;
  assign overflow   = ovf_r;

endmodule
